instruction_fetch: RTL

//  Fetch stage that drives the word address of the synchronous Instruction_memory.
//  It presents each fetched word with its PC to decode over a valid/ready handshake.

---
 rtl/instruction_fetch.sv | 65 ++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage driving a 1-cycle synchronous instruction memory with a valid/ready handoff to decode
module instruction_fetch #(
  parameter int                    ADDR_BITS  = 10,
  parameter int                    DATA_BITS  = 32,
  parameter logic [ADDR_BITS-1:0]  RESET_PC   = '0,
  parameter logic [DATA_BITS-1:0]  HALT_INSTR = {DATA_BITS{1'b1}},
  parameter int                    CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [DATA_BITS-1:0] imem_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 if_valid,
  output logic [DATA_BITS-1:0] if_instr,
  output logic [ADDR_BITS-1:0] if_pc,
  input  logic                 id_ready,
  output logic                 halted,
  output logic [CNT_BITS-1:0]  fetch_cnt,
  output logic [CNT_BITS-1:0]  stall_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_inc;
  logic                 accept, advance, stall;
  // a redirect discards whatever pair is currently on offer
  assign accept   = if_valid && id_ready && !redirect_valid;
  assign advance  = accept && fetch_en;
  assign stall    = if_valid && !id_ready && !redirect_valid;
  assign pc_inc   = pc_q + 1'b1;
  assign if_valid = state_q == RUN;
  assign halted   = state_q == HALT;
  assign if_pc    = pc_q;
  assign if_instr = imem_data;
  // memory address: redirect beats advance beats re-read of the held word
  assign imem_addr = !rst_n ? RESET_PC : redirect_valid ? redirect_pc : advance ? pc_inc : pc_q;
  // next state: any redirect resumes streaming, an accepted HALT word stops it
  always_comb begin
    state_d = redirect_valid ? RUN :
              (state_q == BOOT && fetch_en) ? RUN :
              (accept && if_instr == HALT_INSTR) ? HALT : state_q;
  end
  // state and PC register track the address handed to memory every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= imem_addr;
    end
  end
  // saturating performance counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + 1'b1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
